// File: rtl/binary_multiplier_4bits_if.sv
// Operand/result bundle for the shift-and-add multiplier.
// The master side supplies operands and the start strobe; the slave side returns product, busy and done.
interface binary_multiplier_4bits_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, done
    );
endinterface

// File: rtl/binary_multiplier_4bits.sv
// Mano-style sequential unsigned multiplier: A/B/Q/C/P datapath registers driven by an
// IDLE -> ADD -> SHIFT control FSM, producing a 2*WIDTH-bit product with a one-cycle done pulse.
module binary_multiplier_4bits #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    binary_multiplier_4bits_if.slave      bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADD   = 2'b01,
        SHIFT = 2'b10
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]   a_reg, b_reg, q_reg;
    logic               c_reg;
    logic [CNT_W-1:0]   p_reg;
    logic [2*WIDTH-1:0] product_reg;
    logic               busy_reg, done_reg;

    logic               load_op, add_en, shift_en, finish, abort;
    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;

    assign {add_carry, add_sum} = {1'b0, a_reg} + {1'b0, b_reg};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Control decode; an unused encoding falls back to IDLE and clears busy/done.
    always_comb begin
        next_state = state;
        load_op    = 1'b0;
        add_en     = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load_op    = 1'b1;
                    next_state = ADD;
                end
            end
            ADD: begin
                add_en     = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (p_reg == '0) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = ADD;
                end
            end
            default: begin
                abort      = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            q_reg       <= '0;
            c_reg       <= 1'b0;
            p_reg       <= '0;
            product_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= finish;
            if (load_op) begin
                b_reg    <= bus.multiplicand;
                q_reg    <= bus.multiplier;
                a_reg    <= '0;
                c_reg    <= 1'b0;
                p_reg    <= CNT_W'(WIDTH);
                busy_reg <= 1'b1;
            end
            if (add_en) begin
                if (q_reg[0]) begin
                    a_reg <= add_sum;
                    c_reg <= add_carry;
                end
                p_reg <= p_reg - CNT_W'(1);
            end
            // Logical right shift of {C,A,Q}; the product is captured from the post-shift value.
            if (shift_en) begin
                c_reg <= 1'b0;
                a_reg <= {c_reg, a_reg[WIDTH-1:1]};
                q_reg <= {a_reg[0], q_reg[WIDTH-1:1]};
            end
            if (finish) begin
                product_reg <= {c_reg, a_reg, q_reg[WIDTH-1:1]};
                busy_reg    <= 1'b0;
            end
            if (abort) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign bus.product = product_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
endmodule
